ddr3_pg_arbiter: RTL and testbench

Shares the single DDR3 page-transfer engine (pg_req/pg_ack/pg_optype/pg_req_addr plus its 128-bit DPRAM port) between N_REQ requesters, e.g. the xDOM register path and the waveform-buffer readout path. It runs round-robin arbitration and launches one page transfer at a time. While a transfer runs, it steers the engine's DPRAM port to the granted requester's RAM. It watches each transfer with a timeout and reports completion and error per requester. It runs in the DDR3 UI clock domain.

---
 rtl/ddr3_pg_arbiter.sv | 156 +++++++++++++++
 tb/tb_ddr3_pg_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_pg_arbiter.sv
// ddr3_pg_arbiter: round-robin arbiter sharing one DDR3 page-transfer engine and its DPRAM port
module ddr3_pg_arbiter #(
    parameter int N_REQ     = 2,
    parameter int P_TIMEOUT = 4096,
    parameter int P_ADDR_W  = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cal_complete,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_optype,
    input  logic [N_REQ*P_ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]          req_ack,
    output logic [N_REQ-1:0]          req_err,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      pg_req,
    output logic                      pg_optype,
    output logic [P_ADDR_W-1:0]       pg_req_addr,
    input  logic                      pg_ack,
    input  logic [7:0]                eng_dpram_addr,
    input  logic                      eng_dpram_wren,
    input  logic [127:0]              eng_dpram_din,
    output logic [127:0]              eng_dpram_dout,
    output logic [N_REQ-1:0]          rq_dpram_wren,
    output logic [7:0]                rq_dpram_addr,
    output logic [127:0]              rq_dpram_din,
    input  logic [N_REQ*128-1:0]      rq_dpram_dout,
    output logic [15:0]               n_xfer,
    output logic                      err_sticky,
    input  logic                      err_clr
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(P_TIMEOUT);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d, ack_q, ack_d, err_q, err_d;
    logic [IW-1:0]       ptr_q, ptr_d, gidx_q, gidx_d, sel;
    logic [IW:0]         j;
    logic                found, busy_q, busy_d, pg_req_q, pg_req_d, opt_q, opt_d;
    logic                sticky_q, sticky_d, set_err;
    logic [P_ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         nx_q, nx_d;
    always_comb begin
        sel   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = {1'b0, ptr_q} + (IW+1)'(k);
            j = (j >= (IW+1)'(N_REQ)) ? j - (IW+1)'(N_REQ) : j;
            if (req[j[IW-1:0]]) begin
                sel   = j[IW-1:0];
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        pg_req_d = 1'b0;
        opt_d    = opt_q;
        addr_d   = addr_q;
        ack_d    = '0;
        err_d    = '0;
        cnt_d    = cnt_q;
        nx_d     = nx_q;
        set_err  = 1'b0;
        case (state_q)
            S_IDLE: if (cal_complete && found) begin
                state_d      = S_ISSUE;
                grant_d      = '0;
                grant_d[sel] = 1'b1;
                gidx_d       = sel;
                busy_d       = 1'b1;
                opt_d        = req_optype[sel];
                addr_d       = req_addr[int'(sel)*P_ADDR_W +: P_ADDR_W];
            end
            S_ISSUE: begin
                pg_req_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: if (pg_ack) begin
                ack_d   = grant_q;
                nx_d    = nx_q + 16'd1;
                state_d = S_DONE;
            end else if (cnt_q == CW'(P_TIMEOUT - 1)) begin
                err_d   = grant_q;
                set_err = 1'b1;
                state_d = S_DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = S_IDLE;
            end
        endcase
        // a clear in the same cycle as a timeout wins
        sticky_d = err_clr ? 1'b0 : (set_err | sticky_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            pg_req_q <= 1'b0;
            opt_q    <= 1'b0;
            addr_q   <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
            nx_q     <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            pg_req_q <= pg_req_d;
            opt_q    <= opt_d;
            addr_q   <= addr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            nx_q     <= nx_d;
            sticky_q <= sticky_d;
        end
    end
    always_comb begin
        eng_dpram_dout = '0;
        for (int i = 0; i < N_REQ; i++)
            eng_dpram_dout = eng_dpram_dout | (grant_q[i] ? rq_dpram_dout[i*128 +: 128] : 128'd0);
    end
    assign rq_dpram_wren = {N_REQ{eng_dpram_wren}} & grant_q;
    assign rq_dpram_addr = eng_dpram_addr;
    assign rq_dpram_din  = eng_dpram_din;
    assign req_ack       = ack_q;
    assign req_err       = err_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign pg_req        = pg_req_q;
    assign pg_optype     = opt_q;
    assign pg_req_addr   = addr_q;
    assign n_xfer        = nx_q;
    assign err_sticky    = sticky_q;
endmodule

// File: tb/tb_ddr3_pg_arbiter.sv
// tb_ddr3_pg_arbiter: directed and randomized checks of ddr3_pg_arbiter against a cycle-age model
module tb_ddr3_pg_arbiter;
    localparam int N  = 2;
    localparam int AW = 28;
    localparam int TO = 16;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cal_complete = 1'b0;
    logic [N-1:0]    req = '0, req_optype = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ack, req_err, grant, rq_dpram_wren;
    logic            busy, pg_req, pg_optype, err_sticky, pg_ack = 1'b0, err_clr = 1'b0;
    logic [AW-1:0]   pg_req_addr;
    logic [7:0]      eng_dpram_addr = '0, rq_dpram_addr;
    logic            eng_dpram_wren = 1'b0;
    logic [127:0]    eng_dpram_din = '0, eng_dpram_dout, rq_dpram_din;
    logic [N*128-1:0] rq_dpram_dout = '0;
    logic [15:0]     n_xfer;
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    ddr3_pg_arbiter #(.N_REQ(N), .P_TIMEOUT(TO), .P_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .cal_complete(cal_complete), .req(req), .req_optype(req_optype),
        .req_addr(req_addr), .req_ack(req_ack), .req_err(req_err), .grant(grant), .busy(busy),
        .pg_req(pg_req), .pg_optype(pg_optype), .pg_req_addr(pg_req_addr), .pg_ack(pg_ack),
        .eng_dpram_addr(eng_dpram_addr), .eng_dpram_wren(eng_dpram_wren), .eng_dpram_din(eng_dpram_din),
        .eng_dpram_dout(eng_dpram_dout), .rq_dpram_wren(rq_dpram_wren), .rq_dpram_addr(rq_dpram_addr),
        .rq_dpram_din(rq_dpram_din), .rq_dpram_dout(rq_dpram_dout), .n_xfer(n_xfer),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // model: a transfer is tracked by its age in cycles since grant became visible
    int owner = -1, age = 0, ptr = 0;
    bit fin = 0, mdl_ok = 0;
    logic [N-1:0]  e_grant = '0, e_ack = '0, e_err = '0;
    logic          e_busy = 0, e_pgreq = 0, e_opt = 0, e_sticky = 0;
    logic [AW-1:0] e_addr = '0;
    logic [15:0]   e_nx = '0;
    always @(posedge clk) begin
        bit nack, nerr, nreq;
        int pick;
        if (rst) begin
            owner = -1; fin = 0; age = 0; ptr = 0; mdl_ok = 1;
            e_grant = '0; e_busy = 0; e_pgreq = 0; e_opt = 0; e_addr = '0;
            e_ack = '0; e_err = '0; e_nx = '0; e_sticky = 0;
        end else begin
            nack = 0; nerr = 0; nreq = 0; pick = -1;
            if (owner < 0) begin
                if (cal_complete && req != 0) begin
                    for (int k = 0; k < N; k++)
                        if (pick < 0 && req[(ptr + k) % N]) pick = (ptr + k) % N;
                    owner = pick; age = 0;
                    e_opt = req_optype[pick];
                    e_addr = req_addr[pick*AW +: AW];
                    e_grant = '0; e_grant[pick] = 1'b1; e_busy = 1;
                end
            end else if (fin) begin
                ptr = (owner + 1) % N; owner = -1; fin = 0; e_grant = '0; e_busy = 0;
            end else begin
                if (age == 0) nreq = 1;
                else if (pg_ack) begin nack = 1; e_nx = e_nx + 16'd1; fin = 1; end
                else if (age == TO) begin nerr = 1; fin = 1; end
                age++;
            end
            e_pgreq = nreq;
            e_ack = nack ? e_grant : '0;
            e_err = nerr ? e_grant : '0;
            e_sticky = err_clr ? 1'b0 : (nerr ? 1'b1 : e_sticky);
        end
    end
    always @(negedge clk) begin
        logic [127:0] e_dout;
        #2;
        if (mdl_ok) begin
            e_dout = '0;
            for (int i = 0; i < N; i++) if (e_grant[i]) e_dout = rq_dpram_dout[i*128 +: 128];
            chk("grant", grant, e_grant);
            chk("busy", busy, e_busy);
            chk("pg_req", pg_req, e_pgreq);
            chk("pg_optype", pg_optype, e_opt);
            chk("pg_req_addr", pg_req_addr, e_addr);
            chk("req_ack", req_ack, e_ack);
            chk("req_err", req_err, e_err);
            chk("n_xfer", n_xfer, e_nx);
            chk("err_sticky", err_sticky, e_sticky);
            chk("rq_wren", rq_dpram_wren, eng_dpram_wren ? e_grant : '0);
            chk("eng_dout", eng_dpram_dout, e_dout);
            chk("rq_addr", rq_dpram_addr, eng_dpram_addr);
            chk("rq_din", rq_dpram_din, eng_dpram_din);
        end
    end
    // engine: acks ack_dly cycles after pg_req (-1 never), random delays and stray acks in rnd_mode
    int ack_dly = 0, ack_cnt = 0;
    bit rnd_mode = 0, force_ack = 0;
    always @(negedge clk) begin
        int d;
        #1;
        pg_ack = force_ack;
        if (rst) ack_cnt = 0;
        else begin
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) pg_ack = 1'b1;
            end
            if (pg_req) begin
                d = rnd_mode ? (($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20))) : ack_dly;
                if (d == 0) pg_ack = 1'b1;
                else if (d > 0) ack_cnt = d;
            end
            if (rnd_mode && $urandom_range(0, 49) == 0) pg_ack = 1'b1;
        end
    end
    task automatic wait_for(input int which, input int budget, input string nm, output int n);
        logic hit;
        n = 0; hit = 0;
        while (!hit && n < budget) begin
            @(negedge clk); #3; n++;
            hit = (which == 0) ? pg_req : (which == 1) ? |req_ack : (which == 2) ? |req_err : |grant;
        end
        chk(nm, hit, 1'b1);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1; req = '0; cal_complete = 0; err_clr = 0; force_ack = 0; eng_dpram_wren = 0;
        @(negedge clk);
        rst = 0;
    endtask
    initial begin
        int n, cnt;
        logic [1:0] gseq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        #3;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_nx", n_xfer, 16'd0);
        chk("rst_pgreq", pg_req, 1'b0);
        // single write transfer from requester 0
        @(negedge clk);
        cal_complete = 1; req = 2'b01; req_optype = 2'b01; req_addr[0 +: AW] = 28'h0000100; ack_dly = 10;
        wait_for(0, 10, "t1_launch", n);
        chk("t1_addr", pg_req_addr, 28'h0000100);
        chk("t1_opt", pg_optype, 1'b1);
        wait_for(1, 20, "t1_ack_seen", n);
        chk("t1_ack", req_ack, 2'b01);
        chk("t1_nx", n_xfer, 16'd1);
        @(negedge clk); req = '0;
        @(negedge clk); #3;
        chk("t1_grant_idle", grant, 2'b00);
        // round-robin with both held
        do_reset();
        @(negedge clk);
        cal_complete = 1; req = 2'b11; ack_dly = 5;
        for (int t = 0; t < 4; t++) begin
            wait_for(0, 30, "rr_launch", n);
            chk("rr_grant", grant, gseq[t]);
            wait_for(1, 30, "rr_ack_seen", n);
            chk("rr_ack", req_ack, gseq[t]);
        end
        chk("rr_nx", n_xfer, 16'd4);
        // calibration gating
        do_reset();
        @(negedge clk);
        req = 2'b01; cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #3;
            if (pg_req) cnt++;
        end
        @(negedge clk); cal_complete = 1;
        wait_for(0, 5, "cal_launch", n);
        chk("cal_count", cnt, 0);
        chk("cal_latency", n, 2);
        // timeout, sticky clear, stray ack
        do_reset();
        @(negedge clk);
        cal_complete = 1; req = 2'b01; ack_dly = -1;
        wait_for(0, 10, "to_launch", n);
        wait_for(2, 40, "to_err_seen", n);
        chk("to_latency", n, TO);
        chk("to_err", req_err, 2'b01);
        chk("to_noack", req_ack, 2'b00);
        chk("to_sticky", err_sticky, 1'b1);
        @(negedge clk); req = '0; err_clr = 1;
        @(negedge clk); err_clr = 0; #3;
        chk("to_clr", err_sticky, 1'b0);
        @(negedge clk); force_ack = 1;
        @(negedge clk); force_ack = 0;
        @(negedge clk); #3;
        chk("to_stray_nx", n_xfer, 16'd0);
        // DPRAM steering to requester 1
        do_reset();
        @(negedge clk);
        cal_complete = 1; req = 2'b10; ack_dly = -1;
        wait_for(0, 10, "mux_launch", n);
        @(negedge clk);
        eng_dpram_wren = 1; eng_dpram_addr = 8'h05;
        rq_dpram_dout = {{16{8'hAA}}, {16{8'h55}}};
        #3;
        chk("mux_wren", rq_dpram_wren, 2'b10);
        chk("mux_dout", eng_dpram_dout, {16{8'hAA}});
        chk("mux_addr", rq_dpram_addr, 8'h05);
        // reset during WAIT
        do_reset();
        @(negedge clk);
        cal_complete = 1; req = 2'b01; ack_dly = -1;
        wait_for(0, 10, "rw_launch", n);
        repeat (3) @(negedge clk);
        rst = 1; req = '0;
        @(negedge clk); rst = 0; #3;
        chk("rw_busy", busy, 1'b0);
        chk("rw_grant", grant, 2'b00);
        chk("rw_ackerr", {req_ack, req_err}, 4'b0);
        repeat (2) @(negedge clk);
        force_ack = 1;
        @(negedge clk); force_ack = 0;
        @(negedge clk); #3;
        chk("rw_nx", n_xfer, 16'd0);
        // randomized traffic
        rnd_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            cal_complete = ($urandom_range(0, 9) != 0);
            req = N'($urandom);
            req_optype = N'($urandom);
            for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
            err_clr = ($urandom_range(0, 19) == 0);
            eng_dpram_wren = 1'($urandom);
            eng_dpram_addr = 8'($urandom);
            eng_dpram_din = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < N * 4; i++) rq_dpram_dout[i*32 +: 32] = $urandom;
        end
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
